keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, whole-sweep debounce, single-entry event register.
// Define KEYPAD_RELEASE_EVT_EN to add the key_release output and report key releases.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] rows_in,
    output logic [3:0] cols_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
`ifdef KEYPAD_RELEASE_EVT_EN
    output logic       key_release,
`endif
    output logic       overflow
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [3:0]    DEB_MAX   = 4'(DEBOUNCE_SCANS);

    logic [PW-1:0] presc;
    logic [1:0]    col;
    logic [3:0]    rows_s1;
    logic [3:0]    rows_s2;
    logic [15:0]   snapshot;
    logic [15:0]   prev_snap;
    logic [15:0]   debounced;
    logic [15:0]   deb_d;
    logic [3:0]    stable_cnt;

    logic          tick;
    logic          sweep_end;
    logic [15:0]   snap_full;
    logic [3:0]    stable_next;
    logic [15:0]   press_bits;
    logic          evt;
    logic [3:0]    evt_code;
    logic          handshake;

    assign tick      = (presc == PRESC_MAX);
    assign sweep_end = tick && (col == 2'd3);
    assign cols_out  = ~(4'b0001 << col);
    assign handshake = key_valid && key_ready;

    // Snapshot including the rows sampled at the end of the current column slot.
    always_comb begin
        snap_full = snapshot;
        for (int r = 0; r < 4; r++) begin
            snap_full[{col, 2'(r)}] = ~rows_s2[r];
        end
    end

    always_comb begin
        stable_next = 4'd0;
        if (snap_full == prev_snap) begin
            stable_next = (stable_cnt == DEB_MAX) ? DEB_MAX : stable_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc      <= '0;
            col        <= 2'd0;
            rows_s1    <= 4'd0;
            rows_s2    <= 4'd0;
            snapshot   <= 16'd0;
            prev_snap  <= 16'd0;
            stable_cnt <= 4'd0;
            debounced  <= 16'd0;
            deb_d      <= 16'd0;
        end else begin
            rows_s1 <= rows_in;
            rows_s2 <= rows_s1;
            deb_d   <= debounced;
            if (tick) begin
                presc    <= '0;
                col      <= col + 2'd1;
                snapshot <= snap_full;
            end else begin
                presc <= presc + PW'(1);
            end
            if (sweep_end) begin
                prev_snap  <= snap_full;
                stable_cnt <= stable_next;
                if (stable_next == DEB_MAX) begin
                    debounced <= snap_full;
                end
            end
        end
    end

    // Edges of the debounced state are visible for exactly one cycle after a sweep end.
    assign press_bits = debounced & ~deb_d;

`ifdef KEYPAD_RELEASE_EVT_EN
    logic [15:0] release_bits;
    logic        evt_rel;
    assign release_bits = deb_d & ~debounced;
`endif

    // Lowest index wins; presses take priority over releases.
    always_comb begin
        evt      = 1'b0;
        evt_code = 4'd0;
`ifdef KEYPAD_RELEASE_EVT_EN
        evt_rel  = 1'b0;
`endif
        for (int i = 15; i >= 0; i--) begin
            if (press_bits[i]) begin
                evt      = 1'b1;
                evt_code = 4'(i);
            end
        end
`ifdef KEYPAD_RELEASE_EVT_EN
        if (!evt) begin
            for (int i = 15; i >= 0; i--) begin
                if (release_bits[i]) begin
                    evt      = 1'b1;
                    evt_code = 4'(i);
                    evt_rel  = 1'b1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            overflow  <= 1'b0;
        end else if (evt && (!key_valid || handshake)) begin
            key_valid <= 1'b1;
            key_code  <= evt_code;
        end else begin
            if (handshake) begin
                key_valid <= 1'b0;
            end
            if (evt) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef KEYPAD_RELEASE_EVT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_release <= 1'b0;
        end else if (evt && (!key_valid || handshake)) begin
            key_release <= evt_rel;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2) with a keypad matrix model.
// Release-event checks are included when KEYPAD_RELEASE_EVT_EN is defined.
module tb_keypad_scanner;

    logic        clk;
    logic        reset_n;
    logic [3:0]  rows_in;
    logic [3:0]  cols_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        overflow;
`ifdef KEYPAD_RELEASE_EVT_EN
    logic        key_release;
`endif

    logic [15:0] keys;
    int          cyc;
    int          vcount;
    int          checks;
    int          failures;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rows_in   (rows_in),
        .cols_out  (cols_out),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
`ifdef KEYPAD_RELEASE_EVT_EN
        .key_release (key_release),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key at (col c, row r) pulls row r low while column c is driven low.
    always_comb begin
        rows_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!cols_out[c] && keys[c*4+r]) rows_in[r] = 1'b0;
            end
        end
    end

    function automatic logic [3:0] exp_cols(input int n);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << ((n / 4) % 4));
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (key_valid) vcount++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        vcount    = 0;
        keys      = 16'h0000;
        key_ready = 1'b0;
        reset_n   = 1'b1;
        #2 reset_n = 1'b0;
        #5;
        check("rst_cols", 16'(cols_out), 16'hE);
        check("rst_valid", 16'(key_valid), 16'h0);
        check("rst_code", 16'(key_code), 16'h0);
        check("rst_ovf", 16'(overflow), 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle scan: column rotation every 4 clocks, no events.
        for (int k = 1; k <= 32; k++) begin
            tick();
            check("idle_cols", 16'(cols_out), 16'(exp_cols(cyc)));
        end
        check("idle_no_evt", 16'(vcount), 16'h0);

        // Key 6 held: event one cycle after the 3rd full sweep, then no repeat.
        keys = 16'h0040;
        run_to(80);
        check("k6_early", 16'(key_valid), 16'h0);
        tick();
        check("k6_valid", 16'(key_valid), 16'h1);
        check("k6_code", 16'(key_code), 16'h6);
        check("k6_ovf", 16'(overflow), 16'h0);
        key_ready = 1'b1;
        tick();
        check("k6_hs_clear", 16'(key_valid), 16'h0);
        vcount = 0;
        run_to(144);
        check("k6_no_repeat", 16'(vcount), 16'h0);
        keys = 16'h0000;
`ifdef KEYPAD_RELEASE_EVT_EN
        run_to(192);
        check("k6_rel_early", 16'(key_valid), 16'h0);
        tick();
        check("k6_rel_valid", 16'(key_valid), 16'h1);
        check("k6_rel_code", 16'(key_code), 16'h6);
        check("k6_rel_flag", 16'(key_release), 16'h1);
        run_to(208);
`else
        vcount = 0;
        run_to(208);
        check("k6_rel_no_evt", 16'(vcount), 16'h0);
`endif

        // Bounce on key 6 for 5 sweeps, then stable: exactly one event.
        key_ready = 1'b0;
        vcount = 0;
        for (int s = 0; s < 5; s++) begin
            keys = (s % 2 == 0) ? 16'h0040 : 16'h0000;
            run_to(208 + 16 * (s + 1));
        end
        run_to(320);
        check("bounce_quiet", 16'(vcount), 16'h0);
        tick();
        check("bounce_valid", 16'(key_valid), 16'h1);
        check("bounce_code", 16'(key_code), 16'h6);
        key_ready = 1'b1;
        tick();
        check("bounce_hs", 16'(key_valid), 16'h0);
        vcount = 0;
        run_to(352);
        check("bounce_once", 16'(vcount), 16'h0);
        keys = 16'h0000;
        run_to(416);

        // Keys 3 and 9 in one sweep: lowest index only, no overflow.
        key_ready = 1'b0;
        keys = 16'h0208;
        run_to(464);
        check("k3k9_early", 16'(key_valid), 16'h0);
        tick();
        check("k3k9_valid", 16'(key_valid), 16'h1);
        check("k3k9_code", 16'(key_code), 16'h3);
        check("k3k9_ovf", 16'(overflow), 16'h0);
        key_ready = 1'b1;
        tick();
        check("k3k9_hs", 16'(key_valid), 16'h0);
        check("k3k9_ovf2", 16'(overflow), 16'h0);
        run_to(480);
        keys = 16'h0000;
        run_to(544);

        // Unconsumed key 5, then key 10: dropped, sticky overflow.
        key_ready = 1'b0;
        keys = 16'h0020;
        run_to(593);
        check("k5_valid", 16'(key_valid), 16'h1);
        check("k5_code", 16'(key_code), 16'h5);
        run_to(608);
        keys = 16'h0000;
        run_to(672);
        keys = 16'h0400;
        run_to(720);
`ifndef KEYPAD_RELEASE_EVT_EN
        check("ovf_not_yet", 16'(overflow), 16'h0);
`endif
        tick();
        check("drop_valid", 16'(key_valid), 16'h1);
        check("drop_code", 16'(key_code), 16'h5);
        check("drop_ovf", 16'(overflow), 16'h1);
        key_ready = 1'b1;
        tick();
        check("drop_hs", 16'(key_valid), 16'h0);
        check("ovf_sticky", 16'(overflow), 16'h1);
        keys = 16'h0000;

        // Key 0 press then release.
        run_to(800);
        keys = 16'h0001;
        run_to(849);
        check("k0_valid", 16'(key_valid), 16'h1);
        check("k0_code", 16'(key_code), 16'h0);
`ifdef KEYPAD_RELEASE_EVT_EN
        check("k0_press_flag", 16'(key_release), 16'h0);
`endif
        tick();
        check("k0_hs", 16'(key_valid), 16'h0);
        run_to(864);
        keys = 16'h0000;
`ifdef KEYPAD_RELEASE_EVT_EN
        run_to(913);
        check("k0_rel_valid", 16'(key_valid), 16'h1);
        check("k0_rel_code", 16'(key_code), 16'h0);
        check("k0_rel_flag", 16'(key_release), 16'h1);
        run_to(928);
`else
        vcount = 0;
        run_to(928);
        check("k0_rel_no_evt", 16'(vcount), 16'h0);
`endif

        // Pending key 15 then asynchronous reset mid-sweep.
        key_ready = 1'b0;
        keys = 16'h8000;
        run_to(977);
        check("k15_valid", 16'(key_valid), 16'h1);
        check("k15_code", 16'(key_code), 16'hF);
        run_to(985);
        check("pre_rst_cols", 16'(cols_out), 16'(exp_cols(cyc)));
        #2 reset_n = 1'b0;
        #1;
        check("arst_cols", 16'(cols_out), 16'hE);
        check("arst_valid", 16'(key_valid), 16'h0);
        check("arst_code", 16'(key_code), 16'h0);
        check("arst_ovf", 16'(overflow), 16'h0);
`ifdef KEYPAD_RELEASE_EVT_EN
        check("arst_rel", 16'(key_release), 16'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        run_to(3);
        check("restart_col0", 16'(cols_out), 16'hE);
        tick();
        check("restart_col1", 16'(cols_out), 16'hD);
        run_to(48);
        check("k15_redeb_early", 16'(key_valid), 16'h0);
        tick();
        check("k15_redeb_valid", 16'(key_valid), 16'h1);
        check("k15_redeb_code", 16'(key_code), 16'hF);
        check("k15_redeb_ovf", 16'(overflow), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
